// File: rtl/teras_job_ctrl.sv
// Job sequencer for the teras matrix core: register port, operand FIFO, core handshakes and result capture.
// Defining TERAS_JOB_WDOG_EN adds a 16-bit DRAIN watchdog that ends a stalled job with err set.
module teras_job_ctrl #(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              core_rts_o,
   input  logic              core_rtr_i,
   output logic [DATA_W-1:0] core_data_o,
   input  logic              core_rts_i,
   output logic              core_rtr_o,
   input  logic [DATA_W-1:0] core_data_i,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              irq
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  n_in_q, n_out_q;
   logic [CNT_W-1:0]  acc_cnt_q, sent_cnt_q, out_cnt_q;
   logic [CNT_W-1:0]  acc_cnt_d, sent_cnt_d, out_cnt_d;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]     fill_q;
   logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic              err_q, irq_q, out_valid_q;
   logic [DATA_W-1:0] out_data_q;

   logic wr_ctrl, start_w, abort_w, cfg_zero, job_start, enter_done, wdog_expired;
   logic push, pop, res_xfer, fifo_full, fifo_empty;
   logic unused_wdata;

   assign unused_wdata = ^cfg_wdata[31:CNT_W];

   // Abort dominates start when both bits arrive in one write.
   assign wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
   assign abort_w   = wr_ctrl && cfg_wdata[1];
   assign start_w   = wr_ctrl && cfg_wdata[0] && !cfg_wdata[1];
   assign cfg_zero  = (n_in_q == '0) || (n_out_q == '0);
   assign job_start = start_w && !busy;

   assign fifo_full  = (fill_q == FW'(FIFO_DEPTH));
   assign fifo_empty = (fill_q == '0);
   assign push       = in_valid && in_ready;
   assign pop        = core_rts_o && core_rtr_i;
   assign res_xfer   = core_rts_i && core_rtr_o;

   always_comb begin
      acc_cnt_d  = acc_cnt_q;
      sent_cnt_d = sent_cnt_q;
      out_cnt_d  = out_cnt_q;
      if (abort_w || job_start) begin
         acc_cnt_d  = '0;
         sent_cnt_d = '0;
         out_cnt_d  = '0;
      end else begin
         if (push)     acc_cnt_d  = acc_cnt_q + CNT_W'(1);
         if (pop)      sent_cnt_d = sent_cnt_q + CNT_W'(1);
         if (res_xfer) out_cnt_d  = out_cnt_q + CNT_W'(1);
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state; FEED may skip DRAIN when all results already arrived.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_w) state_d = cfg_zero ? S_DONE : S_FEED;
         end
         S_FEED: begin
            if (sent_cnt_d == n_in_q)
               state_d = (out_cnt_d == n_out_q) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if ((out_cnt_d == n_out_q) || wdog_expired) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_w) state_d = S_IDLE;
   end

   assign enter_done = (state_d == S_DONE) && ((state_q != S_DONE) || start_w);

   // FSM: outputs
   always_comb begin
      in_ready   = 1'b0;
      core_rts_o = 1'b0;
      core_rtr_o = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_FEED: begin
            in_ready   = !fifo_full && (acc_cnt_q < n_in_q);
            core_rts_o = !fifo_empty;
            core_rtr_o = (out_cnt_q < n_out_q);
            busy       = 1'b1;
         end
         S_DRAIN: begin
            core_rtr_o = (out_cnt_q < n_out_q);
            busy       = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_in_q      <= '0;
         n_out_q     <= '0;
         acc_cnt_q   <= '0;
         sent_cnt_q  <= '0;
         out_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         err_q       <= 1'b0;
         irq_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (cfg_we && !busy && (cfg_addr == 2'd1)) n_in_q  <= cfg_wdata[CNT_W-1:0];
         if (cfg_we && !busy && (cfg_addr == 2'd2)) n_out_q <= cfg_wdata[CNT_W-1:0];
         acc_cnt_q  <= acc_cnt_d;
         sent_cnt_q <= sent_cnt_d;
         out_cnt_q  <= out_cnt_d;
         if (abort_w || job_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_q + FW'(push) - FW'(pop);
         end
         if (abort_w)           err_q <= 1'b0;
         else if (job_start)    err_q <= cfg_zero;
         else if (wdog_expired) err_q <= 1'b1;
         irq_q       <= enter_done;
         out_valid_q <= res_xfer;
         if (res_xfer) out_data_q <= core_data_i;
      end
   end

   // Operand storage needs no reset; occupancy is tracked by fill_q.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= in_data;
   end

`ifdef TERAS_JOB_WDOG_EN
   logic [15:0] wdog_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             wdog_q <= '0;
      else if (state_q != S_DRAIN || res_xfer) wdog_q <= '0;
      else if (wdog_q != 16'hFFFF)            wdog_q <= wdog_q + 16'd1;
   end

   assign wdog_expired = (state_q == S_DRAIN) && (wdog_q == 16'hFFFF);
`else
   assign wdog_expired = 1'b0;
`endif

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd1:    cfg_rdata = 32'(n_in_q);
         2'd2:    cfg_rdata = 32'(n_out_q);
         2'd3:    cfg_rdata = {16'(out_cnt_q), 13'd0, err_q, done, busy};
         default: cfg_rdata = '0;
      endcase
   end

   assign core_data_o = fifo_mem_q[rd_ptr_q];
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_teras_job_ctrl.sv
// Directed bench for teras_job_ctrl: queue-based scoreboard of operand order and result latency,
// plus literal expectations per job. The watchdog job runs only when TERAS_JOB_WDOG_EN is defined.
module tb_teras_job_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_addr = 2'd0;
   logic [31:0]   cfg_wdata = '0;
   logic [31:0]   cfg_rdata;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          core_rts_o;
   logic          core_rtr_i = 1'b0;
   logic [DW-1:0] core_data_o;
   logic          core_rts_i = 1'b0;
   logic          core_rtr_o;
   logic [DW-1:0] core_data_i = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          busy, done, irq;

   always #5 clk = ~clk;

   teras_job_ctrl #(.DATA_W(DW), .CNT_W(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_rts_o(core_rts_o), .core_rtr_i(core_rtr_i), .core_data_o(core_data_o),
      .core_rts_i(core_rts_i), .core_rtr_o(core_rtr_o), .core_data_i(core_data_i),
      .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .done(done), .irq(irq)
   );

   int vecs = 0;
   int errs = 0;

   // Model: operands accepted but not yet delivered, job counts, observed event totals.
   logic [DW-1:0] exp_q[$];
   int            acc_m = 0, outs_m = 0, n_in_m = 0, n_out_m = 0;
   int            core_xfers = 0, out_pulses = 0, irq_cnt = 0;
   logic          pend_out = 1'b0;
   logic [DW-1:0] pend_data = '0;
   logic          irq_prev = 1'b0;

   int            res_idx = 0, res_total = 0;
   logic [DW-1:0] res_base = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_start(input int ni, input int no);
      exp_q.delete();
      acc_m   = 0;
      outs_m  = 0;
      n_in_m  = ni;
      n_out_m = no;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_we    = 1'b1;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic host_stream(input int n, input logic [31:0] base, input int budget);
      int   i = 0;
      int   t = 0;
      logic hs;
      in_valid = (n > 0);
      in_data  = base;
      while (i < n && t < budget) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         t++;
         if (hs) i++;
         if (i < n) in_data = base + i;
         else       in_valid = 1'b0;
      end
      in_valid = 1'b0;
      chk("host_words_sent", i, n);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_within_budget", done, 1);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Core result source: presents res_base+k until the block takes it.
   initial begin : core_side
      logic hs;
      forever begin
         @(negedge clk);
         hs = core_rts_i && core_rtr_o;
         @(posedge clk); #1;
         if (hs) res_idx++;
         if (res_idx < res_total) begin
            core_rts_i  = 1'b1;
            core_data_i = res_base + res_idx;
         end else begin
            core_rts_i  = 1'b0;
         end
      end
   end

   // Every-cycle scoreboard, sampled on the falling edge.
   initial begin : compare
      @(posedge rst_n);
      forever begin
         @(negedge clk);
         if (pend_out) begin
            chk("out_valid_latency1", out_valid, 1);
            chk("out_data", out_data, pend_data);
         end else begin
            chk("out_valid_spurious", out_valid, 0);
         end
         if (out_valid) out_pulses++;
         pend_out = 1'b0;
         chk("in_ready_bound", in_ready && (exp_q.size() >= DEPTH || acc_m >= n_in_m), 0);
         chk("core_rts_without_data", core_rts_o && (exp_q.size() == 0), 0);
         chk("core_rtr_bound", core_rtr_o && (outs_m >= n_out_m), 0);
         chk("busy_and_done", busy && done, 0);
         chk("irq_width", irq && irq_prev, 0);
         if (irq) begin
            irq_cnt++;
            chk("irq_needs_done", done, 1);
         end
         irq_prev = irq;
         if (core_rts_o && core_rtr_i && exp_q.size() > 0) begin
            chk("core_data_order", core_data_o, exp_q.pop_front());
            core_xfers++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            acc_m++;
         end
         if (core_rts_i && core_rtr_o) begin
            pend_out  = 1'b1;
            pend_data = core_data_i;
            outs_m++;
         end
      end
   end

   initial begin : watchdog_guard
      #1_500_000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          xf0, op0, iq0;
      logic [31:0] rd;

      repeat (3) @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_core_rts", core_rts_o, 0);
      chk("rst_core_rtr", core_rtr_o, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy_done_irq", {busy, done, irq}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cfg_read(2'd3, rd); chk("rst_status", rd, 0);
      cfg_read(2'd1, rd); chk("rst_n_in", rd, 0);
      cfg_read(2'd2, rd); chk("rst_n_out", rd, 0);

      // Job 1: 4 operands, 2 results, core always ready.
      cfg_write(2'd1, 4); cfg_write(2'd2, 2);
      core_rtr_i = 1'b1; res_base = 'hA000; res_idx = 0; res_total = 2;
      xf0 = core_xfers; op0 = out_pulses; iq0 = irq_cnt;
      model_start(4, 2);
      cfg_write(2'd0, 1);
      host_stream(4, 'h100, 100);
      wait_done(100);
      settle();
      chk("j1_core_xfers", core_xfers - xf0, 4);
      chk("j1_out_pulses", out_pulses - op0, 2);
      chk("j1_irq", irq_cnt - iq0, 1);
      cfg_read(2'd3, rd); chk("j1_status", rd, 32'h0002_0002);
      cfg_read(2'd0, rd); chk("ctrl_reads_zero", rd, 0);
      $display("job1: N_IN=4 N_OUT=2 status=%08h", rd);

      // Job 2: 8 operands against a stalled core; FIFO fills at 4.
      cfg_write(2'd1, 8); cfg_write(2'd2, 1);
      core_rtr_i = 1'b0; res_base = 'hB000; res_idx = 0; res_total = 1;
      xf0 = core_xfers; op0 = out_pulses; iq0 = irq_cnt;
      model_start(8, 1);
      cfg_write(2'd0, 1);
      fork
         host_stream(8, 'h200, 300);
         begin
            repeat (20) @(posedge clk); #1;
            chk("j2_fifo_full_in_ready", in_ready, 0);
            chk("j2_accepted_before_release", acc_m, 4);
            cfg_write(2'd1, 5);
            cfg_read(2'd1, rd); chk("j2_n_in_locked_while_busy", rd, 8);
            cfg_write(2'd0, 1);
            core_rtr_i = 1'b1;
         end
      join
      wait_done(200);
      settle();
      chk("j2_core_xfers", core_xfers - xf0, 8);
      chk("j2_out_pulses", out_pulses - op0, 1);
      chk("j2_irq", irq_cnt - iq0, 1);
      chk("j2_fifo_drained", exp_q.size(), 0);
      cfg_read(2'd3, rd); chk("j2_status", rd, 32'h0001_0002);
      $display("job2: N_IN=8 N_OUT=1 status=%08h", rd);

      // Job 3: core offers 3 results, only 2 wanted.
      cfg_write(2'd1, 2); cfg_write(2'd2, 2);
      res_base = 'hC000; res_idx = 0; res_total = 3;
      xf0 = core_xfers; op0 = out_pulses; iq0 = irq_cnt;
      model_start(2, 2);
      cfg_write(2'd0, 1);
      host_stream(2, 'h300, 100);
      wait_done(100);
      settle();
      chk("j3_excess_held_rtr", core_rtr_o, 0);
      chk("j3_out_pulses", out_pulses - op0, 2);
      chk("j3_core_xfers", core_xfers - xf0, 2);
      cfg_read(2'd3, rd); chk("j3_status", rd, 32'h0002_0002);
      $display("job3: N_IN=2 N_OUT=2 with 3 offered, status=%08h", rd);
      res_total = res_idx;
      settle();

      // Job 4: N_IN=0 is an error start.
      cfg_write(2'd1, 0); cfg_write(2'd2, 1);
      xf0 = core_xfers; iq0 = irq_cnt;
      model_start(0, 1);
      cfg_write(2'd0, 1);
      wait_done(10);
      settle();
      cfg_read(2'd3, rd); chk("j4_status_err_done", rd, 32'h0000_0006);
      chk("j4_no_core_xfers", core_xfers - xf0, 0);
      chk("j4_irq", irq_cnt - iq0, 1);
      $display("job4: N_IN=0 status=%08h", rd);

      // Job 5: abort after 2 of 6 operands (start+abort in one write), then a clean job.
      cfg_write(2'd1, 6); cfg_write(2'd2, 1);
      core_rtr_i = 1'b0; res_idx = 0; res_total = 0;
      iq0 = irq_cnt;
      model_start(6, 1);
      cfg_write(2'd0, 1);
      host_stream(2, 'h400, 50);
      cfg_write(2'd0, 3);
      model_start(0, 0);
      chk("j5_abort_busy", busy, 0);
      chk("j5_abort_done", done, 0);
      chk("j5_abort_core_rts", core_rts_o, 0);
      cfg_read(2'd3, rd); chk("j5_abort_status", rd, 0);
      settle();
      chk("j5_abort_no_irq", irq_cnt - iq0, 0);
      cfg_write(2'd1, 2); cfg_write(2'd2, 1);
      core_rtr_i = 1'b1; res_base = 'hD000; res_idx = 0; res_total = 1;
      xf0 = core_xfers; op0 = out_pulses; iq0 = irq_cnt;
      model_start(2, 1);
      cfg_write(2'd0, 1);
      host_stream(2, 'h500, 100);
      wait_done(100);
      settle();
      chk("j5_after_abort_xfers", core_xfers - xf0, 2);
      chk("j5_after_abort_out", out_pulses - op0, 1);
      chk("j5_after_abort_irq", irq_cnt - iq0, 1);
      cfg_read(2'd3, rd); chk("j5_after_abort_status", rd, 32'h0001_0002);
      $display("job5: abort then N_IN=2 N_OUT=1 status=%08h", rd);

`ifdef TERAS_JOB_WDOG_EN
      begin
         int cyc;
         cfg_write(2'd1, 1); cfg_write(2'd2, 1);
         res_idx = 0; res_total = 0;
         iq0 = irq_cnt;
         model_start(1, 1);
         cfg_write(2'd0, 1);
         host_stream(1, 'h600, 50);
         cyc = 0;
         while (!done && cyc < 70000) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("wdog_fired", done, 1);
         chk("wdog_not_early", cyc >= 65530, 1);
         settle();
         cfg_read(2'd3, rd); chk("wdog_status", rd, 32'h0000_0006);
         chk("wdog_irq", irq_cnt - iq0, 1);
         $display("job6: watchdog after %0d cycles status=%08h", cyc, rd);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/teras_job_ctrl.md
Name: teras_job_ctrl

Overview:
- Job sequencer in front of the teras matrix core.
- Host programs the job size through a small register port, then pushes operand words through a ready/valid stream.
- The block buffers the operands, feeds the core's slave rts/rtr interface and collects the expected number of matrix-C results from the core's master interface.
- Reports busy/done/err and pulses an interrupt at job end; sits between the Wishbone bridge and the teras core.

Parameters:
- DATA_W, 32, operand/result word width.
- CNT_W, 16, width of the job word counters.
- FIFO_DEPTH, 4, operand buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select: 0 CTRL, 1 N_IN, 2 N_OUT, 3 STATUS.
- cfg_wdata  in  32  register write data.
- cfg_rdata  out  32  combinational read of the register at cfg_addr.
- in_valid  in  1  host operand word valid.
- in_ready  out  1  block accepts an operand word.
- in_data  in  DATA_W  host operand word.
- core_rts_o  out  1  operand word valid to core (drives core rts_i).
- core_rtr_i  in  1  core ready for an operand (from core rtr_o).
- core_data_o  out  DATA_W  operand word to core.
- core_rts_i  in  1  core result valid (from core rts_o).
- core_rtr_o  out  1  block accepts a result (drives core rtr_i).
- core_data_i  in  DATA_W  result word from core.
- out_valid  out  1  registered result valid, one cycle per word, no backpressure.
- out_data  out  DATA_W  registered result word.
- busy  out  1  job in progress.
- done  out  1  job finished, sticky.
- irq  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset: FSM to IDLE; all counters, FIFO pointers and N_IN/N_OUT = 0; in_ready, core_rts_o, core_rtr_o, out_valid, busy, done, err, irq = 0; out_data = 0.
- Transfers: a transfer occurs only when valid/rts and ready/rtr are both high in the same cycle.
- Registers:
  - CTRL write: bit0 = start, bit1 = abort. Both are self-clearing; CTRL reads 0.
  - N_IN, N_OUT: low CNT_W bits are used. Writes are ignored while busy.
  - STATUS read: [0] busy, [1] done, [2] err, [31:16] out_cnt (zero-extended or truncated to 16 bits).
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE/DONE + start:
  - N_IN = 0 or N_OUT = 0: set err, enter DONE next cycle, pulse irq.
  - Otherwise: clear done/err and all counters, enter FEED. busy = 1 in FEED and DRAIN.
- FEED:
  - in_ready = !fifo_full && (acc_cnt < N_IN). Each host transfer pushes in_data into the FIFO and increments acc_cnt.
  - core_rts_o = !fifo_empty; core_data_o = FIFO head. Each core transfer pops the FIFO and increments sent_cnt.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full (pop frees the slot in the same cycle; in_ready still follows fifo_full of the current cycle).
  - When sent_cnt reaches N_IN, go to DRAIN.
- Results (FEED and DRAIN): core_rtr_o = (out_cnt < N_OUT). Each result transfer registers core_data_i onto out_data with out_valid high for exactly 1 cycle (latency 1) and increments out_cnt.
- DRAIN: in_ready = 0, core_rts_o = 0. When out_cnt reaches N_OUT, go to DONE.
- Early completion: if out_cnt reaches N_OUT while still in FEED, remain in FEED until all N_IN words are sent, then go directly to DONE (skip DRAIN).
- DONE: done = 1, busy = 0; irq pulses high for the single entry cycle.
- Excess results: after out_cnt reaches N_OUT, core_rtr_o = 0 and any further core results are held off.
- Abort (any state): FSM to IDLE next cycle; FIFO flushed; counters cleared; done/err cleared; no irq. Start and abort in the same write: abort wins.
- Start while in FEED or DRAIN is ignored.
- Counters never wrap: acc_cnt, sent_cnt and out_cnt are bounded by N_IN/N_OUT.
- Reset asserted mid-job: immediate return to the reset state; the FIFO contents are lost.

Optional Feature:
- Macro TERAS_JOB_WDOG_EN.
- Defined: a 16-bit watchdog counter runs in DRAIN. It clears on every result transfer and on DRAIN entry. On reaching 16'hFFFF, set err and enter DONE with an irq pulse.
- Not defined: no watchdog logic; DRAIN waits indefinitely for results.

Test Plan:
- N_IN=4, N_OUT=2, start, host streams 4 words with core_rtr_i=1, core returns 2 results -> 4 core transfers in order, 2 out_valid pulses each 1 cycle after its core transfer, DONE, irq high 1 cycle, STATUS = 0x0002_0002.
- N_IN=8, FIFO_DEPTH=4, core_rtr_i=0 for 20 cycles -> in_ready low after 4 accepted words; release core_rtr_i -> all 8 words delivered in order, no loss or duplication.
- Core returns 3 results while N_OUT=2 -> third result held with core_rtr_o=0; exactly 2 out_valid pulses.
- Abort written mid-FEED after 2 of 6 words -> IDLE next cycle, busy=0, done=0, no irq, FIFO empty; a new job of N_IN=2, N_OUT=1 then completes normally.
- Start with N_IN=0 -> err=1, done=1, irq pulse, no core transfers.
- With TERAS_JOB_WDOG_EN, N_OUT=1 and no result returned -> 65535 cycles after DRAIN entry, err=1, done=1, irq pulse.
